// File: rtl/display_scan.sv
// display_scan: snapshots six 7-segment codes once per frame and scans them onto a shared bus.
module display_scan #(
  parameter int SEGMENTOS       = 7,
  parameter int DIGITS          = 6,
  parameter int TICKS_PER_DIGIT = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [0:SEGMENTOS-1]  D_unidades,
  input  logic [0:SEGMENTOS-1]  D_decenas,
  input  logic [0:SEGMENTOS-1]  D_centenas,
  input  logic [0:SEGMENTOS-1]  D_millares,
  input  logic [0:SEGMENTOS-1]  D_decenas_millares,
  input  logic [0:SEGMENTOS-1]  D_centenas_millares,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [0:SEGMENTOS-1]  seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_start
);
  localparam int PW = $clog2(TICKS_PER_DIGIT);
  typedef logic [0:SEGMENTOS-1] seg_t;
  logic [PW-1:0]     presc_q, presc_d;
  logic [2:0]        idx_q, idx_d;
  seg_t              snap_q [DIGITS];
  seg_t              snap_d [DIGITS];
  seg_t              d_in   [DIGITS];
  logic [DIGITS-1:0] blank_q, blank_d, an_d;
  seg_t              seg_d;
  logic              bad, load, last, dark;
  assign d_in = '{D_unidades, D_decenas, D_centenas, D_millares, D_decenas_millares, D_centenas_millares};
  // Outputs decode the current idx against the next-state snapshot, so a frame's first
  // digit shows the code captured on that very edge.
  always_comb begin
    bad     = idx_q > 3'(DIGITS - 1);
    load    = en && !bad && presc_q == '0 && idx_q == '0;
    last    = presc_q == PW'(TICKS_PER_DIGIT - 1);
    presc_d = bad ? '0 : en ? (last ? '0 : presc_q + 1'b1) : presc_q;
    idx_d   = bad ? '0 : (en && last) ? (idx_q == 3'(DIGITS - 1) ? '0 : idx_q + 3'd1) : idx_q;
    for (int i = 0; i < DIGITS; i++) snap_d[i] = load ? d_in[i] : snap_q[i];
    blank_d = load ? blank_mask : blank_q;
    dark    = !en || bad || blank_d[idx_q];
    seg_d   = dark ? '1 : snap_d[idx_q];
    an_d    = dark ? '1 : ~(DIGITS'(1) << idx_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      snap_q      <= '{default: '1};
      blank_q     <= '1;
      seg_out     <= '1;
      an_out      <= '1;
      frame_start <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      blank_q     <= blank_d;
      seg_out     <= seg_d;
      an_out      <= an_d;
      frame_start <= load;
    end
  end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: table-driven and directed checks of display_scan with 4 ticks per digit.
module tb_display_scan;
  logic       clk = 0, rst = 1, en = 0;
  logic [6:0] d0, d1, d2, d3, d4, d5;
  logic [5:0] blank_mask = '0;
  logic [6:0] seg_out;
  logic [5:0] an_out;
  logic       frame_start;
  int         tests = 0, fails = 0;
  typedef struct {logic r; logic e; logic [5:0] m; logic [6:0] seg; logic [5:0] an; logic fs;} vec_t;
  vec_t       tbl[$];
  logic [6:0] ca [6] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h79};
  logic [6:0] cb [6] = '{7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h08};

  always #5 clk = ~clk;

  display_scan #(.TICKS_PER_DIGIT(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .D_unidades(d0), .D_decenas(d1), .D_centenas(d2), .D_millares(d3),
    .D_decenas_millares(d4), .D_centenas_millares(d5),
    .blank_mask(blank_mask), .seg_out(seg_out), .an_out(an_out), .frame_start(frame_start)
  );

  function automatic logic [5:0] an_of(int d);
    return ~(6'd1 << d);
  endfunction

  function automatic void add(logic r, logic e, logic [5:0] m, logic [6:0] s, logic [5:0] a, logic f);
    vec_t v;
    v.r = r; v.e = e; v.m = m; v.seg = s; v.an = a; v.fs = f;
    tbl.push_back(v);
  endfunction

  function automatic void add_frame(logic [5:0] m);
    for (int j = 0; j < 24; j++) begin
      int d = j / 4;
      add(0, 1, m, m[d] ? 7'h7F : ca[d], m[d] ? 6'h3F : an_of(d), j == 0);
    end
  endfunction

  task automatic chk(string nm, logic [6:0] got, logic [6:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step_chk(string nm, logic [6:0] s, logic [5:0] a, logic f);
    @(posedge clk);
    #1;
    chk({nm, ".seg"}, seg_out, s);
    chk({nm, ".an"}, {1'b0, an_out}, {1'b0, a});
    chk({nm, ".fs"}, {6'd0, frame_start}, {6'd0, f});
  endtask

  task automatic dig(string nm, int d, logic [6:0] c, logic f);
    step_chk(nm, c, an_of(d), f);
  endtask

  task automatic dark(string nm);
    step_chk(nm, 7'h7F, 6'h3F, 1'b0);
  endtask

  initial begin
    {d0, d1, d2, d3, d4, d5} = {ca[0], ca[1], ca[2], ca[3], ca[4], ca[5]};
    for (int i = 0; i < 3; i++) add(1, 0, 6'h00, 7'h7F, 6'h3F, 0);
    add_frame(6'h00);
    add_frame(6'b110000);
    add_frame(6'h00);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r;
      en = tbl[i].e;
      blank_mask = tbl[i].m;
      step_chk($sformatf("vec%0d", i), tbl[i].seg, tbl[i].an, tbl[i].fs);
    end
    // Tearing: D_decenas changes just after the load; old code must survive this frame.
    dig("tear_load", 0, ca[0], 1);
    d1 = 7'h24;
    for (int i = 0; i < 3; i++) dig("tear_d0", 0, ca[0], 0);
    for (int i = 0; i < 4; i++) dig("tear_old", 1, 7'h79, 0);
    for (int d = 2; d < 6; d++) for (int i = 0; i < 4; i++) dig("tear_rest", d, ca[d], 0);
    dig("tear_reload", 0, ca[0], 1);
    for (int i = 0; i < 3; i++) dig("tear_d0b", 0, ca[0], 0);
    for (int i = 0; i < 4; i++) dig("tear_new", 1, 7'h24, 0);
    // Enable: drop at idx=2, presc=1, hold 10 cycles, resume for the remaining 3 ticks.
    dig("en_pre", 2, ca[2], 0);
    en = 0;
    for (int i = 0; i < 10; i++) dark("en_off");
    en = 1;
    for (int i = 0; i < 3; i++) dig("en_resume", 2, ca[2], 0);
    for (int i = 0; i < 4; i++) dig("en_next", 3, ca[3], 0);
    dig("rst_pre", 4, ca[4], 0);
    // Mid-frame reset with fresh codes: the frame restarts at digit 0 with a new snapshot.
    rst = 1;
    {d0, d1, d2, d3, d4, d5} = {cb[0], cb[1], cb[2], cb[3], cb[4], cb[5]};
    dark("mid_rst");
    rst = 0;
    dig("rst_load", 0, cb[0], 1);
    for (int i = 0; i < 3; i++) dig("rst_d0", 0, cb[0], 0);
    for (int d = 1; d < 6; d++) for (int i = 0; i < 4; i++) dig("rst_frame", d, cb[d], 0);
    dig("rst_next", 0, cb[0], 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
